acc_exec: RTL and testbench

- Execute stage directly downstream of the accumulator-control decoder. It consumes the 3-bit AccControl model code plus opcode and operand fields, and owns the architectural accumulator and EQ flag.
- It performs ALU, compare, jump-resolve, register-immediate write and data-memory load/store.
- Memory operations are multi-cycle through a req/ack handshake; the stage back-pressures decode while they are in flight.

---
 rtl/acc_exec_pkg.sv | 33 +++
 rtl/acc_alu.sv | 45 ++++
 rtl/acc_exec.sv | 104 ++++++++++
 tb/tb_acc_exec.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_exec_pkg.sv
// Shared codes for the accumulator execute stage: AccControl models, ALU/unary
// function selects and FSM state encodings.
`timescale 1ns/1ps
package acc_exec_pkg;

  // AccControl model codes produced by the decoder
  localparam logic [2:0] ACC_INVALID = 3'b000;
  localparam logic [2:0] ACC_ALU     = 3'b001;
  localparam logic [2:0] ACC_UNARY   = 3'b010;
  localparam logic [2:0] ACC_EQ      = 3'b011;
  localparam logic [2:0] ACC_JMP     = 3'b100;
  localparam logic [2:0] ACC_STORE   = 3'b101;
  localparam logic [2:0] ACC_LOAD    = 3'b110;
  localparam logic [2:0] ACC_LDI     = 3'b111;

  // op[5:3] selecting add-immediate inside the ALU model
  localparam logic [2:0] OP_HI_ADDI = 3'b010;

  // op[1:0] ALU function, all against rs_data
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // op[2:0] unary function
  localparam logic [2:0] UN_SHL = 3'b101;
  localparam logic [2:0] UN_SHR = 3'b110;

  // FSM states
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/acc_alu.sv
// Next-accumulator datapath for the ALU (001) and unary (010) models; other models pass acc through.
// Latency: purely combinational. Backpressure: none.
`timescale 1ns/1ps
module acc_alu
  import acc_exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        acc_ctl,
  input  logic [5:0]        op,
  input  logic [2:0]        imm,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] alu_acc
);

  logic [DATA_W-1:0] imm_z;

  assign imm_z = {{(DATA_W-3){1'b0}}, imm};

  // Add-immediate takes priority over the op[1:0] function select
  always_comb begin
    alu_acc = acc;
    if (acc_ctl == ACC_ALU) begin
      if (op[5:3] == OP_HI_ADDI) begin
        alu_acc = acc + imm_z;
      end else begin
        case (op[1:0])
          ALU_ADD: alu_acc = acc + rs_data;
          ALU_SUB: alu_acc = acc - rs_data;
          ALU_AND: alu_acc = acc & rs_data;
          ALU_OR:  alu_acc = acc | rs_data;
          default: alu_acc = acc;
        endcase
      end
    end else if (acc_ctl == ACC_UNARY) begin
      case (op[2:0])
        UN_SHL:  alu_acc = acc << 1;
        UN_SHR:  alu_acc = acc >> 1;
        default: alu_acc = acc;
      endcase
    end
  end

endmodule

// File: rtl/acc_exec.sv
// Accumulator execute stage: ALU, compare, jump resolve, reg-immediate write and memory load/store.
// Latency: 1 cycle non-memory, >=2 cycles memory. Backpressure: in_ready low while a memory op waits for mem_ack.
`timescale 1ns/1ps
module acc_exec
  import acc_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        acc_ctl,
  input  logic [5:0]        op,
  input  logic [2:0]        imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] acc,
  output logic              eq_flag,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              branch_taken,
  output logic              illegal,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  logic [0:0]        state;
  logic              accept;
  logic [DATA_W-1:0] alu_acc;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_ctl (acc_ctl),
    .op      (op),
    .imm     (imm),
    .acc     (acc),
    .rs_data (rs_data),
    .alu_acc (alu_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      acc          <= '0;
      eq_flag      <= 1'b0;
      reg_we       <= 1'b0;
      reg_wdata    <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      reg_we       <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          case (acc_ctl)
            ACC_INVALID: illegal <= 1'b1;
            ACC_ALU:     acc <= alu_acc;
            ACC_UNARY:   acc <= alu_acc;
            ACC_EQ:      eq_flag <= (rs_data == rt_data);
            ACC_JMP: begin
              branch_taken <= eq_flag;
              eq_flag      <= 1'b0;
            end
            ACC_LDI: begin
              reg_we    <= 1'b1;
              reg_wdata <= {{(DATA_W-3){1'b0}}, imm};
            end
            ACC_STORE, ACC_LOAD: begin
              // Request fields are captured once here and held until mem_ack
              mem_req   <= 1'b1;
              mem_we    <= (acc_ctl == ACC_STORE);
              mem_addr  <= {{(ADDR_W-3){1'b0}}, imm};
              mem_wdata <= acc;
              state     <= ST_MEM_WAIT;
            end
            default: illegal <= 1'b0;
          endcase
        end
      end else begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= ST_IDLE;
          if (!mem_we) begin
            acc <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_exec.sv
// Directed bench for acc_exec with hand-computed expectations.
`timescale 1ns/1ps
module tb_acc_exec;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] acc_ctl;
  logic [5:0] op;
  logic [2:0] imm;
  logic [7:0] rs_data;
  logic [7:0] rt_data;
  logic [7:0] acc;
  logic       eq_flag;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic       branch_taken;
  logic       illegal;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int checks   = 0;
  int failures = 0;

  acc_exec #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .acc_ctl      (acc_ctl),
    .op           (op),
    .imm          (imm),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .acc          (acc),
    .eq_flag      (eq_flag),
    .reg_we       (reg_we),
    .reg_wdata    (reg_wdata),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [5:0] o, input logic [2:0] i,
                       input logic [7:0] rs, input logic [7:0] rt);
    acc_ctl  = c;
    op       = o;
    imm      = i;
    rs_data  = rs;
    rt_data  = rt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; acc_ctl = 3'b000; op = 6'd0; imm = 3'd0;
    rs_data = 8'd0; rt_data = 8'd0; mem_rdata = 8'd0; mem_ack = 1'b0;
    tick(); tick();

    check("rst_acc", acc, 8'h00);
    check("rst_eq", eq_flag, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_strobes", {reg_we, branch_taken, illegal}, 3'b000);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    tick();

    // Back-to-back add-immediate
    issue(3'b001, 6'b010_000, 3'd5, 8'h00, 8'h00);
    check("addi_1", acc, 8'h05);
    check("addi_1_rdy", in_ready, 1'b1);
    issue(3'b001, 6'b010_000, 3'd5, 8'h00, 8'h00);
    check("addi_2", acc, 8'h0A);
    check("addi_2_rdy", in_ready, 1'b1);

    // 0x0A - 0x0B wraps to 0xFF, then 0xFF + 2 wraps to 0x01
    issue(3'b001, 6'b000_001, 3'd0, 8'h0B, 8'h00);
    check("sub_wrap", acc, 8'hFF);
    issue(3'b001, 6'b000_000, 3'd0, 8'h02, 8'h00);
    check("add_wrap", acc, 8'h01);
    issue(3'b010, 6'b000_101, 3'd0, 8'h00, 8'h00);
    check("shl", acc, 8'h02);
    issue(3'b010, 6'b000_110, 3'd0, 8'h00, 8'h00);
    check("shr", acc, 8'h01);
    issue(3'b010, 6'b000_111, 3'd0, 8'h00, 8'h00);
    check("unary_nop", acc, 8'h01);
    issue(3'b001, 6'b000_011, 3'd0, 8'hF0, 8'h00);
    check("or", acc, 8'hF1);
    issue(3'b001, 6'b000_010, 3'd0, 8'h3C, 8'h00);
    check("and", acc, 8'h30);
    // op[5:3]=010 overrides the sub selected by op[1:0]
    issue(3'b001, 6'b010_001, 3'd7, 8'hFF, 8'h00);
    check("addi_prio", acc, 8'h37);

    // Compare and jump
    issue(3'b011, 6'd0, 3'd0, 8'h33, 8'h33);
    check("eq_set", eq_flag, 1'b1);
    check("eq_acc", acc, 8'h37);
    issue(3'b100, 6'd0, 3'd0, 8'h00, 8'h00);
    check("jmp_taken", branch_taken, 1'b1);
    check("jmp_eq_clr", eq_flag, 1'b0);
    tick();
    check("jmp_pulse_end", branch_taken, 1'b0);
    issue(3'b100, 6'd0, 3'd0, 8'h00, 8'h00);
    check("jmp_not_taken", branch_taken, 1'b0);
    issue(3'b011, 6'd0, 3'd0, 8'h01, 8'h02);
    check("eq_ne", eq_flag, 1'b0);

    // Register-immediate write
    issue(3'b111, 6'd0, 3'd6, 8'h00, 8'h00);
    check("ldi_we", reg_we, 1'b1);
    check("ldi_wdata", reg_wdata, 8'h06);
    check("ldi_acc", acc, 8'h37);
    tick();
    check("ldi_we_end", reg_we, 1'b0);

    // Load with four cycles of ack low; a held instruction must not be accepted
    issue(3'b110, 6'd0, 3'd3, 8'h00, 8'h00);
    acc_ctl = 3'b001; op = 6'b010_000; imm = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ld_req", mem_req, 1'b1);
      check("ld_we", mem_we, 1'b0);
      check("ld_addr", mem_addr, 8'h03);
      check("ld_busy", in_ready, 1'b0);
      tick();
    end
    check("ld_req_5", mem_req, 1'b1);
    check("ld_busy_5", in_ready, 1'b0);
    check("ld_acc_held", acc, 8'h37);
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    check("ld_acc", acc, 8'hA5);
    check("ld_req_drop", mem_req, 1'b0);
    check("ld_ready", in_ready, 1'b1);

    // Build acc=0x5C, then store with same-cycle ack
    issue(3'b001, 6'b000_010, 3'd0, 8'h00, 8'h00);
    issue(3'b001, 6'b000_011, 3'd0, 8'h5C, 8'h00);
    check("pre_store_acc", acc, 8'h5C);
    issue(3'b101, 6'd0, 3'd4, 8'h00, 8'h00);
    check("st_req", mem_req, 1'b1);
    check("st_we", mem_we, 1'b1);
    check("st_addr", mem_addr, 8'h04);
    check("st_wdata", mem_wdata, 8'h5C);
    check("st_busy", in_ready, 1'b0);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    check("st_done_req", mem_req, 1'b0);
    check("st_done_ready", in_ready, 1'b1);
    check("st_acc", acc, 8'h5C);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_acc", acc, 8'h5C);
    check("idle_ack_req", mem_req, 1'b0);

    // Reset during a pending load, then a late ack
    issue(3'b110, 6'd0, 3'd2, 8'h00, 8'h00);
    check("ld2_req", mem_req, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    check("rst_mid_acc", acc, 8'h00);
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_addr", mem_addr, 8'h00);
    check("rst_mid_ready", in_ready, 1'b1);

    issue(3'b000, 6'b111_111, 3'd7, 8'hFF, 8'hFF);
    check("illegal", illegal, 1'b1);
    check("illegal_acc", acc, 8'h00);
    check("illegal_eq", eq_flag, 1'b0);
    check("illegal_others", {reg_we, branch_taken, mem_req}, 3'b000);
    tick();
    check("illegal_end", illegal, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
